// File: rtl/sp_pkg.sv
// Shared widths, fetch FSM states and prefetch buffer entry layout.
package sp_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {FETCH, FULL, FLUSH} fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sp_sync_fifo.sv
// Synchronous FIFO over an arbitrary element type; power-of-two depth,
// pointers wrap naturally. Caller guarantees no push when full / pop when empty.
module sp_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  T              i_data,
  output logic [CW-1:0] o_count,
  output T              o_head
);
  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush && !i_rst) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch stage: owns the PC, prefetches into a small FIFO, handles redirect/flush.
// Optional FETCH_PERF_EN adds fetch and stall counters.
module instr_prefetch_unit
  import sp_pkg::*;
#(
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
`ifdef FETCH_PERF_EN
  output logic [31:0]           perf_fetch_cnt_o,
  output logic [31:0]           perf_stall_cnt_o,
`endif
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  w_req, w_push, w_pop, w_valid;
  logic [CW-1:0]         w_count;
  fetch_entry_t          w_din, w_head;

  // Request depends only on registered state, never on decode backpressure.
  assign w_req   = (r_state == FETCH) & ~rst_i;
  assign w_push  = w_req & imem_ack_i & ~redirect_i;
  assign w_valid = (w_count != '0) & ~rst_i;
  assign w_pop   = w_valid & instr_ready_i & ~redirect_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FETCH: if (w_push && !w_pop && w_count == CW'(FIFO_DEPTH - 1)) w_state_nxt = FULL;
      FULL:  if (w_pop) w_state_nxt = FETCH;
      FLUSH: w_state_nxt = FETCH;
      default: w_state_nxt = FETCH;
    endcase
    if (redirect_i) w_state_nxt = FLUSH;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)           r_pc <= RESET_PC;
    else if (redirect_i) r_pc <= redirect_pc_i;
    else if (w_push)     r_pc <= r_pc + ADDR_WIDTH'(PC_STEP);
  end

  assign w_din.pc    = r_pc;
  assign w_din.instr = imem_rdata_i;

  sp_sync_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_din),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? w_head.instr : '0;
  assign instr_pc_o    = w_valid ? w_head.pc    : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((w_req && !imem_ack_i) || r_state == FULL) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_fetch_cnt;
  assign perf_stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Randomised + directed bench for instr_prefetch_unit against a queue-based model.
module tb_instr_prefetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o, perf_stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  instr_prefetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = RPC;
  bit          m_bub = 1'b0;
  logic [31:0] m_fcnt = '0, m_scnt = '0;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, check outputs, advance model, clock.
  task automatic step(input bit rst, input bit rd, input logic [31:0] rpc,
                      input bit ack, input logic [31:0] dat, input bit rdy);
    bit m_req;
    bit push, pop;
    rst_i = rst; redirect_i = rd; redirect_pc_i = rpc;
    imem_ack_i = ack; imem_rdata_i = dat; instr_ready_i = rdy;
    #1;
    m_req = !m_bub && (q.size() < DEPTH);
    if (!rst) begin
      chk("req",   imem_req_o, m_req);
      chk("addr",  imem_addr_o, m_pc);
      chk("valid", instr_valid_o, q.size() > 0);
      chk("instr", instr_o,    q.size() > 0 ? q[0].ins : 32'h0);
      chk("ipc",   instr_pc_o, q.size() > 0 ? q[0].pc  : 32'h0);
`ifdef FETCH_PERF_EN
      chk("pfetch", perf_fetch_cnt_o, m_fcnt);
      chk("pstall", perf_stall_cnt_o, m_scnt);
`endif
    end
    if (rst) begin
      q.delete(); m_pc = RPC; m_bub = 1'b0; m_fcnt = '0; m_scnt = '0;
    end else begin
      if (m_req ? !ack : (q.size() == DEPTH)) m_scnt++;
      if (rd) begin
        q.delete(); m_pc = rpc; m_bub = 1'b1;
      end else begin
        push = m_req && ack;
        pop  = (q.size() > 0) && rdy;
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back('{pc: m_pc, ins: dat});
          m_pc += 32'd4;
          m_fcnt++;
        end
        m_bub = 1'b0;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input bit ack, input bit rdy);
    step(1'b0, 1'b0, '0, ack, $urandom, rdy);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i);
    #1;
    chk("rst_req",   imem_req_o, 1'b0);
    chk("rst_valid", instr_valid_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_ipc",   instr_pc_o, 32'h0);
    chk("rst_addr",  imem_addr_o, RPC);
    @(negedge clk_i);

    // Streaming: consecutive addresses, data follows one cycle later
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b1);

    // Fill to full, single pop, then one more fetch at 0x110
    do_rst();
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    chk("t2_addr", imem_addr_o, 32'h110);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

    // Ack withheld for three cycles
    do_rst();
    idle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1);
    chk("t3_addr", imem_addr_o, 32'h104);
    for (int i = 0; i < 2; i++) idle(1'b1, 1'b1);

    // Redirect with 3 buffered entries and a same-cycle ack
    do_rst();
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'hDEADBEEF, 1'b1);
    idle(1'b1, 1'b1);
    chk("t4_addr", imem_addr_o, 32'h200);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);

    // PC wrap at top of address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("t5_wrap", imem_addr_o, 32'h0);
    idle(1'b1, 1'b1);

    // Reset mid-operation with entries buffered and a request pending
    do_rst();
    for (int i = 0; i < 2; i++) idle(1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("t6_valid", instr_valid_o, 1'b0);
    idle(1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 300) == 0, ($urandom % 16) == 0, $urandom,
           ($urandom % 4) != 0, $urandom, ($urandom % 5) < 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
